// File: rtl/ip_ttl_update.sv
// rtl/ip_ttl_update.sv - IPv4 TTL decrement with incremental checksum patch and TTL-expiry CPU redirect
// One registered AXI-Stream stage; rewrite is combinational on the accepted first beat.
module ip_ttl_update #(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int SRC_PORT_POS         = 16,
   parameter int DST_PORT_POS         = 24,
   parameter int C_S_AXI_DATA_WIDTH   = 32
) (
   input  logic                                AXI_ACLK,
   input  logic                                reset,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]      S_AXIS_TDATA,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    S_AXIS_TSTRB,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     S_AXIS_TUSER,
   input  logic                                S_AXIS_TVALID,
   input  logic                                S_AXIS_TLAST,
   output logic                                S_AXIS_TREADY,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]      M_AXIS_TDATA,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    M_AXIS_TSTRB,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]     M_AXIS_TUSER,
   output logic                                M_AXIS_TVALID,
   output logic                                M_AXIS_TLAST,
   input  logic                                M_AXIS_TREADY,
   input  logic                                clear_counters,
   output logic [C_S_AXI_DATA_WIDTH-1:0]       ttl_dec_count,
   output logic [C_S_AXI_DATA_WIDTH-1:0]       ttl_expire_count,
   output logic [C_S_AXI_DATA_WIDTH-1:0]       pkt_count
);

   typedef enum logic {ST_HDR, ST_PAYLOAD} state_t;

   state_t                              state_q, state_d;
   logic                                m_valid_q, m_valid_d;
   logic [C_M_AXIS_DATA_WIDTH-1:0]      m_tdata_q, m_tdata_d;
   logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_tstrb_q, m_tstrb_d;
   logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_tuser_q, m_tuser_d;
   logic                                m_tlast_q, m_tlast_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]       dec_cnt_q, dec_cnt_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]       exp_cnt_q, exp_cnt_d;
   logic [C_S_AXI_DATA_WIDTH-1:0]       pkt_cnt_q, pkt_cnt_d;

   logic                                accept;
   logic                                to_cpu, is_ipv4, eligible, do_dec, do_expire, cpu_found;
   logic [7:0]                          ttl, src_port, cpu_port;
   logic [15:0]                         hc, hc_new;
   logic [16:0]                         csum;
   logic [C_S_AXIS_DATA_WIDTH-1:0]      tdata_mod;
   logic [C_S_AXIS_TUSER_WIDTH-1:0]     tuser_mod;

   assign S_AXIS_TREADY = !m_valid_q | M_AXIS_TREADY;
   assign accept        = S_AXIS_TVALID & S_AXIS_TREADY;

   always_comb begin
      ttl      = S_AXIS_TDATA[79:72];
      hc       = S_AXIS_TDATA[63:48];
      src_port = S_AXIS_TUSER[SRC_PORT_POS +: 8];
      // Odd destination bits are the CPU queues.
      to_cpu   = S_AXIS_TUSER[DST_PORT_POS+1] | S_AXIS_TUSER[DST_PORT_POS+3] |
                 S_AXIS_TUSER[DST_PORT_POS+5] | S_AXIS_TUSER[DST_PORT_POS+7];
      is_ipv4  = (S_AXIS_TDATA[159:144] == 16'h0800) & (S_AXIS_TDATA[143:140] == 4'd4);
      eligible = (state_q == ST_HDR) & is_ipv4 & !to_cpu;
      do_dec    = eligible & (ttl >= 8'd2);
      do_expire = eligible & (ttl == 8'd1);

      // RFC 1624 eqn 3: HC' = ~(~HC + ~m + m'), with TTL in the high byte giving -0x0100.
      csum   = {1'b0, ~hc} + 17'h0FEFF;
      hc_new = ~(csum[15:0] + {15'd0, csum[16]});

      cpu_port  = 8'd0;
      cpu_found = 1'b0;
      for (int k = 3; k >= 0; k--) begin
         if (src_port[2*k]) begin
            cpu_port  = 8'd1 << (2*k + 1);
            cpu_found = 1'b1;
         end
      end

      tdata_mod = S_AXIS_TDATA;
      tuser_mod = S_AXIS_TUSER;
      if (do_dec) begin
         tdata_mod[79:72] = ttl - 8'd1;
         tdata_mod[63:48] = hc_new;
      end
      if (do_expire && cpu_found) begin
         tuser_mod[DST_PORT_POS +: 8] = cpu_port;
      end
   end

   always_comb begin
      state_d   = state_q;
      m_valid_d = m_valid_q & !M_AXIS_TREADY;
      m_tdata_d = m_tdata_q;
      m_tstrb_d = m_tstrb_q;
      m_tuser_d = m_tuser_q;
      m_tlast_d = m_tlast_q;
      dec_cnt_d = dec_cnt_q;
      exp_cnt_d = exp_cnt_q;
      pkt_cnt_d = pkt_cnt_q;
      if (accept) begin
         state_d   = S_AXIS_TLAST ? ST_HDR : ST_PAYLOAD;
         m_valid_d = 1'b1;
         m_tdata_d = tdata_mod;
         m_tstrb_d = S_AXIS_TSTRB;
         m_tuser_d = tuser_mod;
         m_tlast_d = S_AXIS_TLAST;
         if (do_dec)       dec_cnt_d = dec_cnt_q + 1'b1;
         if (do_expire)    exp_cnt_d = exp_cnt_q + 1'b1;
         if (S_AXIS_TLAST) pkt_cnt_d = pkt_cnt_q + 1'b1;
      end
      if (clear_counters) begin
         dec_cnt_d = '0;
         exp_cnt_d = '0;
         pkt_cnt_d = '0;
      end
   end

   always_ff @(posedge AXI_ACLK) begin
      if (reset) begin
         state_q   <= ST_HDR;
         m_valid_q <= 1'b0;
         m_tdata_q <= '0;
         m_tstrb_q <= '0;
         m_tuser_q <= '0;
         m_tlast_q <= 1'b0;
         dec_cnt_q <= '0;
         exp_cnt_q <= '0;
         pkt_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         m_valid_q <= m_valid_d;
         m_tdata_q <= m_tdata_d;
         m_tstrb_q <= m_tstrb_d;
         m_tuser_q <= m_tuser_d;
         m_tlast_q <= m_tlast_d;
         dec_cnt_q <= dec_cnt_d;
         exp_cnt_q <= exp_cnt_d;
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   assign M_AXIS_TVALID    = m_valid_q;
   assign M_AXIS_TDATA     = m_tdata_q;
   assign M_AXIS_TSTRB     = m_tstrb_q;
   assign M_AXIS_TUSER     = m_tuser_q;
   assign M_AXIS_TLAST     = m_tlast_q;
   assign ttl_dec_count    = dec_cnt_q;
   assign ttl_expire_count = exp_cnt_q;
   assign pkt_count        = pkt_cnt_q;

endmodule

// File: tb/tb_ip_ttl_update.sv
// tb/tb_ip_ttl_update.sv - self-checking bench for ip_ttl_update
// Directed cases plus randomized packets scored against a behavioural model.
module tb_ip_ttl_update;

   localparam int SRC = 16;
   localparam int DST = 24;

   logic         AXI_ACLK = 1'b0;
   logic         reset = 1'b1;
   logic [255:0] S_AXIS_TDATA = '0;
   logic [31:0]  S_AXIS_TSTRB = '0;
   logic [127:0] S_AXIS_TUSER = '0;
   logic         S_AXIS_TVALID = 1'b0;
   logic         S_AXIS_TLAST = 1'b0;
   logic         S_AXIS_TREADY;
   logic [255:0] M_AXIS_TDATA;
   logic [31:0]  M_AXIS_TSTRB;
   logic [127:0] M_AXIS_TUSER;
   logic         M_AXIS_TVALID;
   logic         M_AXIS_TLAST;
   logic         M_AXIS_TREADY = 1'b1;
   logic         clear_counters = 1'b0;
   logic [31:0]  ttl_dec_count, ttl_expire_count, pkt_count;

   ip_ttl_update dut (
      .AXI_ACLK(AXI_ACLK), .reset(reset),
      .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB), .S_AXIS_TUSER(S_AXIS_TUSER),
      .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TREADY(S_AXIS_TREADY),
      .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB), .M_AXIS_TUSER(M_AXIS_TUSER),
      .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
      .clear_counters(clear_counters), .ttl_dec_count(ttl_dec_count),
      .ttl_expire_count(ttl_expire_count), .pkt_count(pkt_count)
   );

   always #5 AXI_ACLK = ~AXI_ACLK;

   typedef struct {
      logic [255:0] data;
      logic [127:0] user;
      logic [31:0]  strb;
      logic         last;
      logic         first;
   } beat_t;

   beat_t        exp_q[$];
   beat_t        mon_e;
   int           n_tests = 0;
   int           n_fail = 0;
   int           rdy_mode = 0;
   logic [31:0]  m_dec = '0, m_exp = '0, m_pkt = '0;
   logic [255:0] last_hdr_d = '0;
   logic [127:0] last_hdr_u = '0;
   logic         prev_stall = 1'b0;
   logic [416:0] prev_out = '0;

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [255:0] mk_hdr(input logic [15:0] eth, input logic [3:0] ver,
                                           input logic [7:0] ttl, input logic [15:0] hc);
      logic [255:0] r;
      r = rand256();
      r[159:144] = eth;
      r[143:140] = ver;
      r[79:72]   = ttl;
      r[63:48]   = hc;
      return r;
   endfunction

   // Reference: what the stage must emit for one input beat, from the forwarding rules.
   function automatic beat_t model(input logic [255:0] d, input logic [127:0] u, input logic [31:0] s,
                                   input logic l, input logic first, output logic dec, output logic expd);
      beat_t b;
      int    sum;
      logic [7:0] src;
      b.data = d; b.user = u; b.strb = s; b.last = l; b.first = first;
      dec = 1'b0; expd = 1'b0;
      if (first && d[159:144] == 16'h0800 && d[143:140] == 4'd4 &&
          !(u[DST+1] || u[DST+3] || u[DST+5] || u[DST+7])) begin
         if (d[79:72] >= 8'd2) begin
            dec = 1'b1;
            b.data[79:72] = d[79:72] - 8'd1;
            sum = (65535 - int'(d[63:48])) + 65279;
            if (sum > 65535) sum = sum - 65535;
            b.data[63:48] = 16'(65535 - sum);
         end else if (d[79:72] == 8'd1) begin
            expd = 1'b1;
            src  = u[SRC +: 8];
            for (int k = 0; k < 4; k++) begin
               if (src[2*k]) begin
                  b.user[DST +: 8] = 8'(1 << (2*k + 1));
                  break;
               end
            end
         end
      end
      return b;
   endfunction

   initial begin
      forever begin
         @(posedge AXI_ACLK);
         #1;
         case (rdy_mode)
            1:       M_AXIS_TREADY = ((($time / 10) % 3) == 0);
            2:       M_AXIS_TREADY = 1'($urandom_range(0, 1));
            default: M_AXIS_TREADY = 1'b1;
         endcase
      end
   end

   always @(negedge AXI_ACLK) begin
      if (reset) begin
         prev_stall = 1'b0;
      end else begin
         check("s_ready", S_AXIS_TREADY, !M_AXIS_TVALID || M_AXIS_TREADY);
         if (prev_stall) begin
            check("hold_valid", M_AXIS_TVALID, 1'b1);
            check("hold_data", {M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TSTRB, M_AXIS_TLAST}, prev_out);
         end
         if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            check("beat_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("tdata", M_AXIS_TDATA, mon_e.data);
               check("tuser", M_AXIS_TUSER, mon_e.user);
               check("tstrb_tlast", {M_AXIS_TSTRB, M_AXIS_TLAST}, {mon_e.strb, mon_e.last});
               if (mon_e.first) begin
                  last_hdr_d = M_AXIS_TDATA;
                  last_hdr_u = M_AXIS_TUSER;
               end
            end
         end
         prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
         prev_out   = {M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TSTRB, M_AXIS_TLAST};
      end
   end

   task automatic send_beat(input logic [255:0] d, input logic [127:0] u, input logic [31:0] s,
                            input logic l, input logic first, input logic clr);
      beat_t e;
      logic  dec, expd;
      int    n;
      S_AXIS_TDATA = d; S_AXIS_TUSER = u; S_AXIS_TSTRB = s; S_AXIS_TLAST = l;
      S_AXIS_TVALID = 1'b1;
      clear_counters = clr;
      n = 0;
      @(negedge AXI_ACLK);
      while (!S_AXIS_TREADY && n < 200) begin
         n++;
         @(negedge AXI_ACLK);
      end
      check("accept", S_AXIS_TREADY, 1'b1);
      if (S_AXIS_TREADY) begin
         e = model(d, u, s, l, first, dec, expd);
         exp_q.push_back(e);
         if (clr) begin
            m_dec = '0; m_exp = '0; m_pkt = '0;
         end else begin
            if (dec)  m_dec = m_dec + 1;
            if (expd) m_exp = m_exp + 1;
            if (l)    m_pkt = m_pkt + 1;
         end
         @(posedge AXI_ACLK);
         #1;
         check("latency", M_AXIS_TVALID, 1'b1);
      end
      S_AXIS_TVALID = 1'b0;
      clear_counters = 1'b0;
   endtask

   task automatic send_pkt(input logic [255:0] hdr, input logic [7:0] src, input logic [7:0] dst,
                           input int nb, input logic pat);
      logic [127:0] u;
      logic [255:0] d;
      u = {$urandom, $urandom, $urandom, $urandom};
      u[SRC +: 8] = src;
      u[DST +: 8] = dst;
      for (int i = 0; i < nb; i++) begin
         d = (i == 0) ? hdr : rand256();
         if (i != 0 && pat) begin
            d[159:144] = 16'h0800; d[143:140] = 4'd4; d[79:72] = 8'h40;
         end
         send_beat(d, u, $urandom, i == nb - 1, i == 0, 1'b0);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || M_AXIS_TVALID) && n < 300) begin
         @(negedge AXI_ACLK);
         n++;
      end
      check("drain", exp_q.size() == 0 && !M_AXIS_TVALID, 1'b1);
      @(posedge AXI_ACLK);
      #1;
   endtask

   task automatic check_counters(input string tag);
      check({tag, "_dec"}, ttl_dec_count, m_dec);
      check({tag, "_exp"}, ttl_expire_count, m_exp);
      check({tag, "_pkt"}, pkt_count, m_pkt);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      S_AXIS_TVALID = 1'b0;
      clear_counters = 1'b0;
      repeat (2) @(posedge AXI_ACLK);
      #1;
      exp_q.delete();
      m_dec = '0; m_exp = '0; m_pkt = '0;
      check("rst_tvalid", M_AXIS_TVALID, 1'b0);
      check("rst_out", {M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TSTRB, M_AXIS_TLAST}, 417'd0);
      check_counters("rst");
      reset = 1'b0;
      @(posedge AXI_ACLK);
      #1;
      check("rst_s_ready", S_AXIS_TREADY, 1'b1);
   endtask

   task automatic pulse_clear();
      clear_counters = 1'b1;
      @(posedge AXI_ACLK);
      #1;
      clear_counters = 1'b0;
      m_dec = '0; m_exp = '0; m_pkt = '0;
   endtask

   logic [255:0] h;
   logic [7:0]   src_r, dst_r;
   int           kind;

   initial begin
      do_reset();

      // Basic decrement, 3 beats.
      send_pkt(mk_hdr(16'h0800, 4'd4, 8'h40, 16'hB1E6), 8'h01, 8'h01, 3, 1'b0);
      drain();
      check("dec_ttl", last_hdr_d[79:72], 8'h3F);
      check("dec_hc", last_hdr_d[63:48], 16'hB2E6);
      check("dec_cnt", ttl_dec_count, 32'd1);
      check("dec_pkt", pkt_count, 32'd1);

      // Checksum wrap cases.
      send_pkt(mk_hdr(16'h0800, 4'd4, 8'h05, 16'hFF00), 8'h01, 8'h04, 1, 1'b0);
      drain();
      check("wrap_ttl", last_hdr_d[79:72], 8'h04);
      check("wrap_hc_ff00", last_hdr_d[63:48], 16'h0001);
      send_pkt(mk_hdr(16'h0800, 4'd4, 8'h05, 16'hFEFF), 8'h01, 8'h04, 2, 1'b0);
      drain();
      check("wrap_hc_feff", last_hdr_d[63:48], 16'h0000);

      // TTL expiry redirect.
      pulse_clear();
      h = mk_hdr(16'h0800, 4'd4, 8'h01, 16'h1234);
      send_pkt(h, 8'h04, 8'h04, 2, 1'b0);
      drain();
      check("exp_dst", last_hdr_u[DST +: 8], 8'h08);
      check("exp_data", last_hdr_d, h);
      check("exp_cnt", ttl_expire_count, 32'd1);
      check("exp_dec", ttl_dec_count, 32'd0);

      // Passthrough: to-CPU, ARP with IPv4-looking payload, TTL 0.
      pulse_clear();
      send_pkt(mk_hdr(16'h0800, 4'd4, 8'h40, 16'h5555), 8'h01, 8'h02, 2, 1'b0);
      send_pkt(mk_hdr(16'h0806, 4'd4, 8'h40, 16'h5555), 8'h01, 8'h01, 3, 1'b1);
      h = mk_hdr(16'h0800, 4'd4, 8'h00, 16'hAAAA);
      send_pkt(h, 8'h01, 8'h10, 1, 1'b0);
      drain();
      check("pass_ttl0", last_hdr_d, h);
      check("pass_dec", ttl_dec_count, 32'd0);
      check("pass_exp", ttl_expire_count, 32'd0);
      check("pass_pkt", pkt_count, 32'd3);

      // Backpressure with 1,0,0 ready pattern.
      rdy_mode = 1;
      send_pkt(mk_hdr(16'h0800, 4'd4, 8'h22, 16'h0F0F), 8'h10, 8'h40, 4, 1'b1);
      drain();
      rdy_mode = 0;
      check_counters("bp");

      // Reset mid-packet, then a fresh packet.
      h = mk_hdr(16'h0800, 4'd4, 8'h33, 16'h0000);
      send_beat(h, 128'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
      send_beat(rand256(), 128'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
      do_reset();
      send_pkt(mk_hdr(16'h0800, 4'd4, 8'h10, 16'h4321), 8'h01, 8'h01, 2, 1'b0);
      drain();
      check("post_rst_ttl", last_hdr_d[79:72], 8'h0F);
      check("post_rst_dec", ttl_dec_count, 32'd1);

      // Clear coincident with an eligible single-beat packet.
      send_beat(mk_hdr(16'h0800, 4'd4, 8'h09, 16'h1111), {96'd0, 8'h01, 8'h01, 16'd0},
                32'hFFFFFFFF, 1'b1, 1'b1, 1'b1);
      drain();
      check("clr_dec", ttl_dec_count, 32'd0);
      check("clr_pkt", pkt_count, 32'd0);

      // Randomized traffic under random backpressure.
      rdy_mode = 2;
      for (int p = 0; p < 80; p++) begin
         kind  = $urandom_range(0, 6);
         src_r = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(1 << $urandom_range(0, 7));
         dst_r = 8'(1 << $urandom_range(0, 7));
         h = mk_hdr((kind == 1) ? 16'h0806 : 16'h0800, (kind == 2) ? 4'd6 : 4'd4,
                    (kind == 3) ? 8'h01 : (kind == 4) ? 8'h00 : (kind == 5) ? 8'h02 : 8'($urandom),
                    16'($urandom));
         send_pkt(h, src_r, dst_r, $urandom_range(1, 4), 1'($urandom_range(0, 1)));
      end
      drain();
      rdy_mode = 0;
      check_counters("rand");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
